neuron_weight_loader: RTL and testbench
=======================================

// Module: neuron_weight_loader
// PURPOSE
// - Write-side counterpart of the per-neuron synchronous weight ROMs: streams weight words into per-neuron weight RAMs.
// - Accepts words on a valid/ready input stream and issues registered single-word writes, neuron by neuron, address by address.
// - Sits between the off-chip/config interface and the layer's neuron weight memories.
// - Signals completion so the layer controller can start inference.
// PARAMETERS
// - DEPTH        3  address bits per neuron memory (2**DEPTH words per neuron)
// - WIDTH        8  bits per weight word
// - NUM_NEURONS  4  neuron memories in the layer (>=1); SEL_W = max(1,$clog2(NUM_NEURONS))
// PORTS
// - clk_i      in   1      single clock, rising edge
// - reset_n_i  in   1      asynchronous, active-low reset
// - start_i    in   1      pulse: begin a full load (honoured in IDLE and DONE only)
// - data_i     in   WIDTH  weight word
// - valid_i    in   1      data_i valid
// - ready_o    out  1      loader accepts data_i this cycle
// - we_o       out  1      write strobe to neuron memories
// - wsel_o     out  SEL_W  target neuron index
// - waddr_o    out  DEPTH  word address within the target neuron
// - wdata_o    out  WIDTH  write data
// - busy_o     out  1      load in progress (state LOAD)
// - done_o     out  1      all NUM_NEURONS*2**DEPTH words written; held until next start_i
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE; addr_cnt=0, sel_cnt=0; all outputs 0.
// - FSM states: IDLE, LOAD, DONE.
//   - IDLE --start_i--> LOAD, counters cleared.
//   - LOAD --last handshake (sel_cnt==NUM_NEURONS-1 && addr_cnt==2**DEPTH-1)--> DONE.
//   - DONE --start_i--> LOAD: counters cleared, done_o drops the next cycle.
// - ready_o = (state==LOAD); combinational from state, not from valid_i. Handshake = valid_i & ready_o.
// - start_i in LOAD is ignored; there is no restart mid-load.
// - Counters:
//   - Each handshake increments addr_cnt.
//   - On addr_cnt==2**DEPTH-1, addr_cnt wraps to 0 and sel_cnt increments.
//   - sel_cnt never exceeds NUM_NEURONS-1.
// - Write latency 1: handshake at cycle t gives we_o=1 at t+1, with wsel_o/waddr_o = counters at t and wdata_o = data_i at t.
//   - we_o=0 on cycles after no handshake; wsel_o/waddr_o/wdata_o hold their last values.
// - done_o rises at t+1 of the last handshake, the same cycle as the final we_o. busy_o falls in that same cycle.
// - valid_i while not in LOAD: no handshake, data dropped, no write.
// - valid_i gaps (bubbles) in LOAD: no write, counters hold.
// - Reset mid-load: everything returns to reset values; any pending write is discarded (we_o=0).
// - Memories written earlier keep partial contents; the controller must re-run a full load.
// - Counter widths: addr_cnt DEPTH bits, natural wrap. sel_cnt SEL_W bits with explicit compare, so non-power-of-2 NUM_NEURONS works.
// STRUCTURE
// - Package nwl_pkg: typedef enum logic [1:0] {IDLE, LOAD, DONE} nwl_state_t; function sel_width(n).
// - One sub-module: nwl_write_stage, a registered write-port stage.
//   - Inputs: handshake, counters, data.
//   - Outputs: we_o/wsel_o/waddr_o/wdata_o.
//   - Clear on reset.
// - Top holds the FSM and counters. No memory is instantiated inside the loader.
// TESTING (DEPTH=3, WIDTH=8, NUM_NEURONS=4 unless noted)
// - Reset check: reset_n_i=0 mid-stream -> all outputs 0 immediately (async); after release ready_o=0, state IDLE.
// - Full load: start_i, then 32 back-to-back valid words 0x00..0x1F.
//   - Write k goes to wsel=k/8, waddr=k%8, wdata=k, one cycle after its handshake.
//   - done_o=1 and busy_o=0 with the 32nd we_o.
// - Bubbles: same load with valid_i random 50% -> identical write sequence, no extra we_o, done_o after exactly 32 writes.
// - Ignored inputs: valid_i=1 in IDLE/DONE -> ready_o=0, no we_o; start_i in LOAD at word 5 -> counters unaffected.
// - Reset at word 13 then restart: first post-restart write is wsel=0, waddr=0; done_o after 32 new writes.
// - NUM_NEURONS=3: sel wraps at 2; done_o after 24 writes; wsel never reaches 3.

Source files
------------

// File: rtl/nwl_pkg.sv
// Shared types and helpers for the neuron weight loader.
// Holds the FSM state type and the select-width helper.
package nwl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } nwl_state_t;

    // Width of the neuron select; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nwl_write_stage.sv
// Registered single-word write port toward the neuron weight RAMs.
// Ports: hs_i/sel_i/addr_i/data_i in, we_o/wsel_o/waddr_o/wdata_o out.
module nwl_write_stage #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             hs_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic [DEPTH-1:0] addr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             we_o,
    output logic [SEL_W-1:0] wsel_o,
    output logic [DEPTH-1:0] waddr_o,
    output logic [WIDTH-1:0] wdata_o
);

    logic             we_d,    we_q;
    logic [SEL_W-1:0] wsel_d,  wsel_q;
    logic [DEPTH-1:0] waddr_d, waddr_q;
    logic [WIDTH-1:0] wdata_d, wdata_q;

    // Strobe follows the handshake; address/data hold between writes.
    always_comb begin
        we_d    = hs_i;
        wsel_d  = wsel_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (hs_i) begin
            wsel_d  = sel_i;
            waddr_d = addr_i;
            wdata_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            we_q    <= 1'b0;
            wsel_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            wsel_q  <= wsel_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we_o    = we_q;
    assign wsel_o  = wsel_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/neuron_weight_loader.sv
// Streams weight words into per-neuron weight RAMs, neuron by neuron.
// Ports: start_i/data_i/valid_i in, ready_o, write port, busy_o/done_o out.
module neuron_weight_loader
    import nwl_pkg::*;
#(
    parameter  int DEPTH       = 3,
    parameter  int WIDTH       = 8,
    parameter  int NUM_NEURONS = 4,
    localparam int SEL_W       = sel_width(NUM_NEURONS)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             we_o,
    output logic [SEL_W-1:0] wsel_o,
    output logic [DEPTH-1:0] waddr_o,
    output logic [WIDTH-1:0] wdata_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_NEURONS - 1);

    nwl_state_t       state_d, state_q;
    logic [DEPTH-1:0] addr_cnt_d, addr_cnt_q;
    logic [SEL_W-1:0] sel_cnt_d, sel_cnt_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             hs;
    logic             last_addr;
    logic             last_sel;

    assign ready_o   = (state_q == LOAD);
    assign hs        = valid_i & ready_o;
    assign last_addr = (addr_cnt_q == '1);
    // Explicit compare so a non-power-of-2 neuron count wraps correctly.
    assign last_sel  = (sel_cnt_q == SEL_LAST);

    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        sel_cnt_d  = sel_cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d    = LOAD;
                    addr_cnt_d = '0;
                    sel_cnt_d  = '0;
                end
            end
            LOAD: begin
                if (hs) begin
                    if (last_addr) begin
                        addr_cnt_d = '0;
                        if (last_sel) begin
                            sel_cnt_d = '0;
                            state_d   = DONE;
                        end else begin
                            sel_cnt_d = sel_cnt_q + SEL_W'(1);
                        end
                    end else begin
                        addr_cnt_d = addr_cnt_q + DEPTH'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                addr_cnt_d = '0;
                sel_cnt_d  = '0;
            end
        endcase
    end

    // Status outputs are registered images of the next state.
    assign busy_d = (state_d == LOAD);
    assign done_d = (state_d == DONE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            addr_cnt_q <= '0;
            sel_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            sel_cnt_q  <= sel_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

    nwl_write_stage #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_write_stage (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .hs_i      (hs),
        .sel_i     (sel_cnt_q),
        .addr_i    (addr_cnt_q),
        .data_i    (data_i),
        .we_o      (we_o),
        .wsel_o    (wsel_o),
        .waddr_o   (waddr_o),
        .wdata_o   (wdata_o)
    );

endmodule

// File: tb/tb_neuron_weight_loader.sv
// Bench for neuron_weight_loader: a 4-neuron and a 3-neuron instance.
// Expected writes are queued when driven and checked when we_o fires.
module tb_neuron_weight_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start [2];
    logic [7:0] data  [2];
    logic       valid [2];
    logic       ready [2];
    logic       we    [2];
    logic [1:0] wsel  [2];
    logic [2:0] waddr [2];
    logic [7:0] wdata [2];
    logic       busy  [2];
    logic       done  [2];

    typedef struct {
        int  dut;
        int  sel;
        int  addr;
        int  data;
        bit  last;
    } wr_t;

    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    always #5 clk = ~clk;

    neuron_weight_loader #(.DEPTH(3), .WIDTH(8), .NUM_NEURONS(4)) u_dut4 (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start[0]),
        .data_i(data[0]), .valid_i(valid[0]), .ready_o(ready[0]),
        .we_o(we[0]), .wsel_o(wsel[0]), .waddr_o(waddr[0]),
        .wdata_o(wdata[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    neuron_weight_loader #(.DEPTH(3), .WIDTH(8), .NUM_NEURONS(3)) u_dut3 (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start[1]),
        .data_i(data[1]), .valid_i(valid[1]), .ready_o(ready[1]),
        .we_o(we[1]), .wsel_o(wsel[1]), .waddr_o(waddr[1]),
        .wdata_o(wdata[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: every we_o must match the oldest queued write.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (we[d]) begin
                    if (exp_q.size() == 0 || exp_q[0].dut != d) begin
                        check("spurious_we", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wsel", 32'(wsel[d]), 32'(e.sel));
                        check("waddr", 32'(waddr[d]), 32'(e.addr));
                        check("wdata", 32'(wdata[d]), 32'(e.data));
                        if (e.last) begin
                            check("done_last", 32'(done[d]), 32'd1);
                            check("busy_last", 32'(busy[d]), 32'd0);
                        end else begin
                            check("done_early", 32'(done[d]), 32'd0);
                        end
                    end
                end
            end
        end
    end

    task automatic check_zero(input int d, input string tag);
        check({tag, "_we"}, 32'(we[d]), 32'd0);
        check({tag, "_wsel"}, 32'(wsel[d]), 32'd0);
        check({tag, "_waddr"}, 32'(waddr[d]), 32'd0);
        check({tag, "_wdata"}, 32'(wdata[d]), 32'd0);
        check({tag, "_busy"}, 32'(busy[d]), 32'd0);
        check({tag, "_done"}, 32'(done[d]), 32'd0);
        check({tag, "_ready"}, 32'(ready[d]), 32'd0);
    endtask

    // Full load of dut d with nn neurons; optional bubbles, a stray
    // start pulse at word glitch_k, or a reset in place of word reset_k.
    task automatic run_load(input int d, input int nn, input bit bubbles,
                            input int glitch_k, input int reset_k);
        int k;
        int total;
        bit v;
        total = nn * 8;
        @(negedge clk);
        start[d] = 1'b1;
        valid[d] = 1'b0;
        @(negedge clk);
        start[d] = 1'b0;
        check("ready_load", 32'(ready[d]), 32'd1);
        check("busy_load", 32'(busy[d]), 32'd1);
        check("done_clr", 32'(done[d]), 32'd0);
        k = 0;
        while (k < total) begin
            if (k == reset_k) begin
                valid[d] = 1'b1;
                rst_n = 1'b0;
                #1;
                check_zero(d, "rst_mid");
                exp_q.delete();
                @(negedge clk);
                valid[d] = 1'b0;
                rst_n = 1'b1;
                #1;
                check("rst_ready", 32'(ready[d]), 32'd0);
                check("rst_busy", 32'(busy[d]), 32'd0);
                return;
            end
            v = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            valid[d] = v;
            data[d] = 8'(k + 8'h40 * d);
            start[d] = (k == glitch_k) && v;
            if (v) begin
                exp_q.push_back('{d, k / 8, k % 8, (k + 'h40 * d) & 'hff,
                                  k == total - 1});
                k++;
            end
            @(negedge clk);
        end
        valid[d] = 1'b0;
        start[d] = 1'b0;
        @(negedge clk);
        check("done_hold", 32'(done[d]), 32'd1);
        check("busy_end", 32'(busy[d]), 32'd0);
        check("ready_end", 32'(ready[d]), 32'd0);
        check("q_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // valid_i outside LOAD must be ignored.
    task automatic idle_valid(input int d, input bit exp_done);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid[d] = 1'b1;
            data[d] = 8'hA5;
            #1;
            check("ign_ready", 32'(ready[d]), 32'd0);
            check("ign_done", 32'(done[d]), 32'(exp_done));
        end
        @(negedge clk);
        valid[d] = 1'b0;
        #1;
        check("ign_we", 32'(we[d]), 32'd0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            valid[d] = 1'b0;
            data[d]  = 8'h00;
        end
        #2;
        check_zero(0, "por4");
        check_zero(1, "por3");
        @(negedge clk);
        rst_n = 1'b1;
        idle_valid(0, 1'b0);
        idle_valid(1, 1'b0);
        run_load(0, 4, 1'b0, 5, -1);
        idle_valid(0, 1'b1);
        run_load(0, 4, 1'b1, -1, -1);
        run_load(0, 4, 1'b0, -1, 13);
        run_load(0, 4, 1'b0, -1, -1);
        run_load(1, 3, 1'b0, -1, -1);
        idle_valid(1, 1'b1);
        run_load(1, 3, 1'b1, 7, -1);
        repeat (3) @(negedge clk);
        check("final_q", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
